multicycle_main_control: RTL and testbench

//   Multicycle MIPS main control FSM; sits directly upstream of ALUcontrol and drives its ALUop[2:0].

---
 rtl/multicycle_main_control.sv | 171 +++++++++++++++++
 tb/tb_multicycle_main_control.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle MIPS main control FSM (fetch/decode/execute/memory/writeback)
// Optional BNE_EN: decodes opcode 6'b000101 as bne through the BR state with branch_ne=1.
module multicycle_main_control #(
    parameter logic [5:0] OP_LW  = 6'b100011,
    parameter logic [5:0] OP_SW  = 6'b101011,
    parameter logic [5:0] OP_BEQ = 6'b000100,
    parameter logic [5:0] OP_J   = 6'b000010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       branch_ne,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUop,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6, S_REX    = 4'd7,
        S_RWB    = 4'd8,  S_BR    = 4'd9,  S_JMP    = 4'd10, S_IEX   = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    state_t state_q, state_d;
    logic   is_mem, is_branch, is_itype, op_legal;

`ifdef BNE_EN
    localparam logic [5:0] OP_BNE = 6'b000101;
    logic is_bne;
    assign is_bne = (opcode == OP_BNE);
`else
    logic is_bne;
    assign is_bne = 1'b0;
`endif

    assign is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_branch = (opcode == OP_BEQ) || is_bne;
    assign is_itype  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign op_legal  = is_mem || is_branch || is_itype || (opcode == OP_RTYPE) || (opcode == OP_J);

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem)                  state_d = S_MEMADR;
                else if (opcode == OP_RTYPE) state_d = S_REX;
                else if (is_branch)          state_d = S_BR;
                else if (opcode == OP_J)     state_d = S_JMP;
                else if (is_itype)           state_d = S_IEX;
                else                         state_d = S_FETCH;
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_REX:    state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BR:     state_d = S_FETCH;
            S_JMP:    state_d = S_FETCH;
            S_IEX:    state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    assign state_dbg = state_q;

    // Outputs decode straight from the state so an async reset clears them in the same cycle.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        branch_ne   = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUop       = 3'b000;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = !op_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUop   = 3'b010;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BR: begin
                ALUSrcA     = 1'b1;
                ALUop       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                branch_ne   = is_bne;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_ANDI)     ALUop = 3'b011;
                else if (opcode == OP_ORI) ALUop = 3'b100;
                else                       ALUop = 3'b000;
            end
            S_IWB: RegWrite = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - directed and randomized instruction streams against an instruction-level model
module tb_multicycle_main_control;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUop;
    logic [3:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_main_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .branch_ne(branch_ne),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUop(ALUop),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } ctl_t;

    typedef struct {
        ctl_t       c;
        logic       mr;
        logic [5:0] op;
        string      tag;
    } step_t;

    ctl_t  obs;
    step_t q[$];

    assign obs = {state_dbg, PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite,
                  IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop, illegal_op};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010;
    localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] BNE = 6'b000101;

    function automatic logic [5:0] rnd6();
        logic [31:0] r;
        r = $urandom;
        return r[5:0];
    endfunction

    function automatic logic rbit();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    function automatic ctl_t blank(input int st);
        ctl_t c;
        c = '0;
        c.st = st[3:0];
        return c;
    endfunction

    function automatic logic bne_ok();
`ifdef BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input ctl_t c, input logic mr, input logic [5:0] op, input string tag);
        step_t s;
        s.c = c; s.mr = mr; s.op = op; s.tag = tag;
        q.push_back(s);
    endtask

    // Expected per-cycle control trace of one instruction, by instruction class.
    task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input string name);
        ctl_t c;
        logic is_br;
        is_br = (op == BEQ) || (op == BNE && bne_ok());
        for (int i = 0; i <= fw; i++) begin
            c = blank(1); c.mrd = 1'b1; c.srcb = 2'b01;
            if (i == fw) begin c.irw = 1'b1; c.pcw = 1'b1; end
            push(c, (i == fw), rnd6(), {name, "/fetch"});
        end
        c = blank(2); c.srcb = 2'b11;
        c.ill = !(op == LW || op == SW || op == RT || is_br || op == J ||
                  op == ADDI || op == ANDI || op == ORI);
        push(c, rbit(), op, {name, "/decode"});
        if (op == LW || op == SW) begin
            c = blank(3); c.srca = 1'b1; c.srcb = 2'b10;
            push(c, rbit(), op, {name, "/memadr"});
            for (int i = 0; i <= mw; i++) begin
                c = blank(op == LW ? 4 : 6); c.iord = 1'b1;
                if (op == LW) c.mrd = 1'b1; else c.mwr = 1'b1;
                push(c, (i == mw), op, {name, "/mem"});
            end
            if (op == LW) begin
                c = blank(5); c.rw = 1'b1; c.m2r = 1'b1;
                push(c, rbit(), op, {name, "/memwb"});
            end
        end else if (op == RT) begin
            c = blank(7); c.srca = 1'b1; c.aluop = 3'b010;
            push(c, rbit(), op, {name, "/rex"});
            c = blank(8); c.rw = 1'b1; c.rdst = 1'b1;
            push(c, rbit(), op, {name, "/rwb"});
        end else if (is_br) begin
            c = blank(9); c.srca = 1'b1; c.aluop = 3'b001; c.pcwc = 1'b1; c.pcsrc = 2'b01;
            c.bne = (op == BNE);
            push(c, rbit(), op, {name, "/br"});
        end else if (op == J) begin
            c = blank(10); c.pcw = 1'b1; c.pcsrc = 2'b10;
            push(c, rbit(), op, {name, "/jmp"});
        end else if (op == ADDI || op == ANDI || op == ORI) begin
            c = blank(11); c.srca = 1'b1; c.srcb = 2'b10;
            c.aluop = (op == ANDI) ? 3'b011 : (op == ORI) ? 3'b100 : 3'b000;
            push(c, rbit(), op, {name, "/iex"});
            c = blank(12); c.rw = 1'b1;
            push(c, rbit(), op, {name, "/iwb"});
        end
    endtask

    task automatic chk(input ctl_t e, input string tag);
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h (state %0d) expected %h (state %0d)", tag, obs, obs.st, e, e.st);
        end
    endtask

    task automatic run_all();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            mem_ready = s.mr;
            opcode    = s.op;
            @(negedge clk);
            chk(s.c, s.tag);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] table_ops [10];
        logic [31:0] r;
        ctl_t c;
        table_ops = '{RT, LW, SW, BEQ, J, ADDI, ANDI, ORI, BNE, 6'b111111};

        @(negedge clk);
        chk(blank(0), "reset_idle");
        @(posedge clk);
        #1 rst = 1'b0;
        push(blank(0), 1'b0, 6'd0, "idle_after_reset");

        add_instr(RT,   0, 0, "rtype");
        add_instr(LW,   1, 3, "lw_wait3");
        add_instr(ORI,  0, 0, "ori");
        add_instr(6'b111111, 0, 0, "illegal");
        add_instr(BNE,  0, 0, "bne");
        add_instr(SW,   2, 2, "sw_wait2");
        add_instr(BEQ,  0, 0, "beq");
        add_instr(J,    0, 0, "j");
        add_instr(ANDI, 1, 0, "andi");
        add_instr(ADDI, 0, 0, "addi");
        add_instr(SW,   0, 0, "sw_nowait");
        run_all();

        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            add_instr((r[1:0] != 2'b00) ? table_ops[$urandom_range(0, 9)] : rnd6(),
                      $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end
        run_all();

        // lw held in MEMRD, then reset lands mid-cycle.
        add_instr(LW, 0, 5, "lw_rst");
        for (int i = 0; i < 5; i++) void'(q.pop_back());
        run_all();
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk(blank(0), "async_reset_midcycle");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(blank(0), "idle_after_midreset");
        @(posedge clk);
        #1;
        @(negedge clk);
        c = blank(1); c.mrd = 1'b1; c.srcb = 2'b01;
        chk(c, "fetch_after_midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
